w_buf_pp: RTL

Parametrised double-buffered (ping-pong) weight buffer. It packs narrow weight words from the loader into full PE-array rows of NCH channels x KK taps x DW bits. One bank serves rows to the convolution array while the other bank fills. The active bank is reused cyclically until the next weight set is complete. It then swaps in at a set boundary without stalling the array.

---
 rtl/w_buf_pp_if.sv | 29 ++
 rtl/w_buf_pp.sv | 134 +++++++++++++
 2 files changed

// File: rtl/w_buf_pp_if.sv
// Loader, array and status signals of the ping-pong weight buffer.
// Loader handshake: a word transfers on a clock edge where w_in_vld & w_in_rdy are both high;
// w_in_rdy never depends on w_in_vld, and an un-accepted word carries no obligation.
interface w_buf_pp_if #(
   parameter int IN_W  = 128,
   parameter int AW    = 8,
   parameter int ROW_W = 1152
);
   logic             w_in_vld;
   logic [IN_W-1:0]  w_in;
   logic             w_in_rdy;
   logic [AW:0]      w_len;
   logic             data_vld_in;
   logic [ROW_W-1:0] w_out;
   logic             w_out_vld;
   logic             bank_sel;
   logic             w_swap;
   logic             rd_err;

   modport master (
      output w_in_vld, w_in, w_len, data_vld_in,
      input  w_in_rdy, w_out, w_out_vld, bank_sel, w_swap, rd_err
   );

   modport slave (
      input  w_in_vld, w_in, w_len, data_vld_in,
      output w_in_rdy, w_out, w_out_vld, bank_sel, w_swap, rd_err
   );
endinterface

// File: rtl/w_buf_pp.sv
// Ping-pong weight buffer: packs loader words into PE rows in one bank while the other
// bank is replayed to the array; a completed set swaps in only at a set boundary.
module w_buf_pp #(
   parameter int DW    = 8,
   parameter int KK    = 9,
   parameter int NCH   = 16,
   parameter int IN_W  = 128,
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input logic       clk_200M,
   input logic       rst,
   w_buf_pp_if.slave bus
);
   localparam int ROW_W = NCH * KK * DW;
   localparam int WPR   = ROW_W / IN_W;
   localparam int WCW   = (WPR > 1) ? $clog2(WPR) : 1;
   localparam logic [AW:0]    DEPTH_L = (AW+1)'(DEPTH);
   localparam logic [AW:0]    ONE_L   = (AW+1)'(1);
   localparam logic [WCW-1:0] WC_LAST = WCW'(WPR - 1);

   logic [ROW_W-1:0]     mem [0:2*DEPTH-1];
   logic [1:0]           full_q, full_d;
   logic                 fb_q, fb_d, ab_q, ab_d;
   logic [WCW-1:0]       wc_q, wc_d;
   logic [AW-1:0]        wr_row_q, wr_row_d, rd_row_q, rd_row_d;
   logic [AW:0]          len_fill_q, len_fill_d;
   logic [1:0][AW:0]     len_q, len_d;
   logic [ROW_W-1:0]     stage_q, stage_d, w_out_q;
   logic                 w_out_vld_q, w_swap_q, w_swap_d, rd_err_q, rd_err_d, run_q;
   logic                 accept, set_start, row_done, set_done, boundary;
   logic [AW:0]          w_len_clamp, eff_len;

   always_comb begin
      w_len_clamp = (bus.w_len == '0 || bus.w_len > DEPTH_L) ? DEPTH_L : bus.w_len;
      accept      = bus.w_in_vld & run_q & ~full_q[fb_q];
      set_start   = (wr_row_q == '0) && (wc_q == '0);
      // The set length is only known from w_len while the first word is on the bus.
      eff_len     = set_start ? w_len_clamp : len_fill_q;
      row_done    = accept && (wc_q == WC_LAST);
      set_done    = row_done && ({1'b0, wr_row_q} == eff_len - ONE_L);
      boundary    = full_q[ab_q] && ({1'b0, rd_row_q} == len_q[ab_q] - ONE_L);

      stage_d    = stage_q;
      wc_d       = wc_q;
      wr_row_d   = wr_row_q;
      len_fill_d = len_fill_q;
      len_d      = len_q;
      full_d     = full_q;
      fb_d       = fb_q;
      ab_d       = ab_q;
      rd_row_d   = rd_row_q;
      w_swap_d   = 1'b0;
      rd_err_d   = rd_err_q;

      if (accept) begin
         stage_d[IN_W*wc_q +: IN_W] = bus.w_in;
         if (set_start) len_fill_d = w_len_clamp;
         if (row_done) begin
            wc_d     = '0;
            wr_row_d = wr_row_q + AW'(1);
         end else begin
            wc_d = wc_q + WCW'(1);
         end
         if (set_done) begin
            full_d[fb_q] = 1'b1;
            len_d[fb_q]  = eff_len;
            fb_d         = ~fb_q;
            wr_row_d     = '0;
         end
      end

      if (bus.data_vld_in) begin
         if (!full_q[ab_q]) begin
            rd_err_d = 1'b1;
         end else if (boundary) begin
            rd_row_d = '0;
            // Swap only to a set that was already complete before this edge.
            if (full_q[~ab_q]) begin
               full_d[ab_q] = 1'b0;
               ab_d         = ~ab_q;
               w_swap_d     = 1'b1;
            end
         end else begin
            rd_row_d = rd_row_q + AW'(1);
         end
      end
   end

   always_ff @(posedge clk_200M) begin
      if (row_done) mem[{fb_q, wr_row_q}] <= stage_d;
   end

   always_ff @(posedge clk_200M or posedge rst) begin
      if (rst) begin
         full_q      <= '0;
         fb_q        <= 1'b0;
         ab_q        <= 1'b0;
         wc_q        <= '0;
         wr_row_q    <= '0;
         rd_row_q    <= '0;
         len_fill_q  <= '0;
         len_q       <= '0;
         stage_q     <= '0;
         w_out_q     <= '0;
         w_out_vld_q <= 1'b0;
         w_swap_q    <= 1'b0;
         rd_err_q    <= 1'b0;
         run_q       <= 1'b0;
      end else begin
         full_q      <= full_d;
         fb_q        <= fb_d;
         ab_q        <= ab_d;
         wc_q        <= wc_d;
         wr_row_q    <= wr_row_d;
         rd_row_q    <= rd_row_d;
         len_fill_q  <= len_fill_d;
         len_q       <= len_d;
         stage_q     <= stage_d;
         w_out_q     <= mem[{ab_q, rd_row_q}];
         w_out_vld_q <= full_q[ab_q];
         w_swap_q    <= w_swap_d;
         rd_err_q    <= rd_err_d;
         run_q       <= 1'b1;
      end
   end

   assign bus.w_in_rdy  = run_q & ~full_q[fb_q];
   assign bus.w_out     = w_out_q;
   assign bus.w_out_vld = w_out_vld_q;
   assign bus.bank_sel  = ab_q;
   assign bus.w_swap    = w_swap_q;
   assign bus.rd_err    = rd_err_q;
endmodule
